obstacle_sequencer: RTL

Game-level scheduler for the obstacle datapath: it picks which obstacle generator is active, drives the 4-bit select code shared by the generators and the 16-to-1 obstacle mux, and enforces a frame-counted gap between obstacles. It counts completed obstacles and declares victory after a programmed number of them. It sits between the OR of all generator `done` outputs and the obstacle select/counter logic in the obstacles top level, and replaces the fixed-order control.

---
 rtl/obstacle_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/obstacle_sequencer.sv
// Game-level obstacle scheduler: random pick with no immediate repeat, frame-counted
// idle gap before each obstacle, completion counting and victory detection.
module obstacle_sequencer #(
    parameter int         NUM_OBSTACLES = 8,
    parameter logic [3:0] IDLE_CODE     = 4'hF,
    parameter int         GAP_FRAMES    = 60,
    parameter int         WIN_COUNT     = 16,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play_selected,
    input  logic        game_on,
    input  logic        vsync_in,
    input  logic        done_in,
    output logic [3:0]  obstacle_code,
    output logic        obstacle_active,
    output logic        done_out,
    output logic [15:0] obstacles_counted,
    output logic        victory
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PICK   = 3'd1;
    localparam logic [2:0] S_GAP    = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_WIN    = 3'd4;

    localparam logic [3:0]  NUM_L = 4'(NUM_OBSTACLES);
    localparam logic [7:0]  GAP_L = 8'(GAP_FRAMES);
    localparam logic [15:0] WIN_L = 16'(WIN_COUNT);

    logic [2:0]  state_q, state_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        vsync_q;
    logic [3:0]  last_code_q, last_code_d;
    logic [3:0]  chosen_q, chosen_d;
    logic [3:0]  try_q, try_d;
    logic [7:0]  frame_q, frame_d;
    logic [3:0]  code_q, code_d;
    logic        active_q, active_d;
    logic        done_out_q, done_out_d;
    logic [15:0] count_q, count_d;
    logic        victory_q, victory_d;

    logic        tick;
    logic [3:0]  cand;
    logic        cand_ok;
    logic [4:0]  last_inc;
    logic [3:0]  fallback;
    logic        start_req;

    assign tick      = vsync_in & ~vsync_q;
    assign cand      = lfsr_q[3:0];
    assign start_req = play_selected & game_on;

    // With a single valid code, a repeat is the only possible choice.
    assign cand_ok   = (cand < NUM_L) && ((cand != last_code_q) || (NUM_L == 4'd1));
    assign last_inc  = {1'b0, last_code_q} + 5'd1;

    always_comb begin
        fallback = 4'd0;
        if (last_code_q != IDLE_CODE && last_inc < {1'b0, NUM_L}) begin
            fallback = last_inc[3:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        last_code_d = last_code_q;
        chosen_d    = chosen_q;
        try_d       = try_q;
        frame_d     = frame_q;
        count_d     = count_q;
        done_out_d  = 1'b0;

        // Abort wins over everything, including a done_in in the same cycle.
        if (state_q != S_IDLE && !game_on) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_req) begin
                        state_d     = S_PICK;
                        count_d     = 16'd0;
                        last_code_d = IDLE_CODE;
                        try_d       = 4'd0;
                    end
                end
                S_PICK: begin
                    if (cand_ok) begin
                        chosen_d    = cand;
                        last_code_d = cand;
                        frame_d     = 8'd0;
                        state_d     = S_GAP;
                    end else if (try_q == 4'hF) begin
                        chosen_d    = fallback;
                        last_code_d = fallback;
                        frame_d     = 8'd0;
                        state_d     = S_GAP;
                    end else begin
                        try_d = try_q + 4'd1;
                    end
                end
                S_GAP: begin
                    if (frame_q == GAP_L) begin
                        state_d = S_ACTIVE;
                    end else if (tick) begin
                        frame_d = frame_q + 8'd1;
                    end
                end
                S_ACTIVE: begin
                    if (done_in) begin
                        done_out_d = 1'b1;
                        count_d    = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                        if (count_d == WIN_L) begin
                            state_d = S_WIN;
                        end else begin
                            state_d = S_PICK;
                            try_d   = 4'd0;
                        end
                    end
                end
                S_WIN: begin
                    if (start_req) begin
                        state_d = S_PICK;
                        count_d = 16'd0;
                        try_d   = 4'd0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        code_d    = (state_d == S_ACTIVE) ? chosen_d : IDLE_CODE;
        active_d  = (state_d == S_ACTIVE);
        victory_d = (state_d == S_WIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lfsr_q      <= LFSR_SEED;
            vsync_q     <= 1'b0;
            last_code_q <= IDLE_CODE;
            chosen_q    <= IDLE_CODE;
            try_q       <= 4'd0;
            frame_q     <= 8'd0;
            code_q      <= IDLE_CODE;
            active_q    <= 1'b0;
            done_out_q  <= 1'b0;
            count_q     <= 16'd0;
            victory_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            vsync_q     <= vsync_in;
            last_code_q <= last_code_d;
            chosen_q    <= chosen_d;
            try_q       <= try_d;
            frame_q     <= frame_d;
            code_q      <= code_d;
            active_q    <= active_d;
            done_out_q  <= done_out_d;
            count_q     <= count_d;
            victory_q   <= victory_d;
        end
    end

    assign obstacle_code     = code_q;
    assign obstacle_active   = active_q;
    assign done_out          = done_out_q;
    assign obstacles_counted = count_q;
    assign victory           = victory_q;

endmodule
